// File: rtl/uart_rx_framer.sv
// rtl/uart_rx_framer.sv - byte-stream framer: SOF/LEN/payload[/CKSUM] to a buffered payload stream
// Optional feature macro: UART_RX_FRAMER_CKSUM_EN (adds the trailing XOR checksum byte and its check)
module uart_rx_framer #(
  parameter logic [7:0] SOF_BYTE     = 8'h7E,
  parameter int         MAX_LEN      = 16,
  parameter int         TIMEOUT_CLKS = 20 * (50_000_000 / 9600)
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Rx_DV,
  input  logic [7:0] i_Rx_Byte,
  output logic       o_Msg_Valid,
  output logic [7:0] o_Msg_Byte,
  output logic       o_Msg_Last,
  input  logic       i_Msg_Ready,
  output logic       o_Frame_Err,
  output logic       o_Overrun,
  output logic       o_Busy
);

  localparam int          AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0]  MAX_LEN_B = 8'(MAX_LEN);
  // Expiry is detected on the clock that would take the counter to TIMEOUT_CLKS.
  localparam logic [23:0] TMO_LAST  = 24'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_CKSUM = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  wr_idx_q, wr_idx_d;
  logic [7:0]  rd_idx_q, rd_idx_d;
  logic [7:0]  xor_q, xor_d;
  logic [23:0] tmo_q, tmo_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        mem_we;
  logic        timed;
  logic        tmo_hit;

  // Payload buffer, sized to a power of two so the index slice covers it exactly.
  logic [7:0]  mem_q [0:(1 << AW) - 1];

  // Next-state, buffer write enable and error pulses.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    wr_idx_d    = wr_idx_q;
    rd_idx_d    = rd_idx_q;
    xor_d       = xor_q;
    tmo_d       = tmo_q;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    mem_we      = 1'b0;

    // The inter-byte timer only runs while a frame is being collected.
    timed   = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CKSUM);
    // An arriving byte always beats a coincident expiry.
    tmo_hit = timed && !i_Rx_DV && (tmo_q == TMO_LAST);

    if (i_Rx_DV) begin
      tmo_d = 24'd0;
    end else if (timed) begin
      tmo_d = tmo_q + 24'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (i_Rx_DV && (i_Rx_Byte == SOF_BYTE)) begin
          state_d = S_LEN;
        end
      end

      S_LEN: begin
        if (i_Rx_DV) begin
          if ((i_Rx_Byte == 8'd0) || (i_Rx_Byte > MAX_LEN_B)) begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end else begin
            len_d    = i_Rx_Byte;
            xor_d    = i_Rx_Byte;
            wr_idx_d = 8'd0;
            state_d  = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (i_Rx_DV) begin
          mem_we   = 1'b1;
          xor_d    = xor_q ^ i_Rx_Byte;
          wr_idx_d = wr_idx_q + 8'd1;
          if (wr_idx_q == (len_q - 8'd1)) begin
`ifdef UART_RX_FRAMER_CKSUM_EN
            state_d  = S_CKSUM;
`else
            rd_idx_d = 8'd0;
            state_d  = S_DRAIN;
`endif
          end
        end
      end

`ifdef UART_RX_FRAMER_CKSUM_EN
      S_CKSUM: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte == xor_q) begin
            rd_idx_d = 8'd0;
            state_d  = S_DRAIN;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end
        end
      end
`endif

      S_DRAIN: begin
        // The buffer is frozen while it is being read out, so new bytes are lost.
        if (i_Rx_DV) begin
          overrun_d = 1'b1;
        end
        if (i_Msg_Ready) begin
          if (rd_idx_q == (len_q - 8'd1)) begin
            rd_idx_d = 8'd0;
            state_d  = S_IDLE;
          end else begin
            rd_idx_d = rd_idx_q + 8'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (tmo_hit) begin
      frame_err_d = 1'b1;
      tmo_d       = 24'd0;
      state_d     = S_IDLE;
    end
  end

  // State, indices, running XOR, timer and registered pulses.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state_q     <= S_IDLE;
      len_q       <= 8'd0;
      wr_idx_q    <= 8'd0;
      rd_idx_q    <= 8'd0;
      xor_q       <= 8'd0;
      tmo_q       <= 24'd0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      xor_q       <= xor_d;
      tmo_q       <= tmo_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // Payload buffer write; contents are only ever read after a complete frame.
  always_ff @(posedge i_Clock) begin
    if (mem_we) begin
      mem_q[wr_idx_q[AW-1:0]] <= i_Rx_Byte;
    end
  end

  assign o_Msg_Valid = (state_q == S_DRAIN);
  assign o_Msg_Byte  = o_Msg_Valid ? mem_q[rd_idx_q[AW-1:0]] : 8'h00;
  assign o_Msg_Last  = o_Msg_Valid && (rd_idx_q == (len_q - 8'd1));
  assign o_Frame_Err = frame_err_q;
  assign o_Overrun   = overrun_q;
  assign o_Busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
// tb/tb_uart_rx_framer.sv - directed self-checking bench for uart_rx_framer
module tb_uart_rx_framer;

  localparam int TMO = 40;
`ifdef UART_RX_FRAMER_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       msg_valid;
  logic [7:0] msg_byte;
  logic       msg_last;
  logic       msg_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_framer #(
    .SOF_BYTE    (8'h7E),
    .MAX_LEN     (16),
    .TIMEOUT_CLKS(TMO)
  ) dut (
    .i_Clock    (clk),
    .i_Reset_n  (rst_n),
    .i_Rx_DV    (rx_dv),
    .i_Rx_Byte  (rx_byte),
    .o_Msg_Valid(msg_valid),
    .o_Msg_Byte (msg_byte),
    .o_Msg_Last (msg_last),
    .i_Msg_Ready(msg_ready),
    .o_Frame_Err(frame_err),
    .o_Overrun  (overrun),
    .o_Busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         vec_n  = 0;
  int         miss_n = 0;
  int         cyc    = 0;
  int         cap_n  = 0;
  int         err_n  = 0;
  int         ovr_n  = 0;
  int         vld_n  = 0;
  int         dbl_n  = 0;
  bit         err_prev = 1'b0;
  bit         ovr_prev = 1'b0;
  logic [7:0] cap_b [0:255];
  logic       cap_l [0:255];
  int         cap_c [0:255];

  // Mid-cycle observer: inputs change just after posedge, so negedge sees the upcoming handshake.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (msg_valid && msg_ready && cap_n < 256) begin
      cap_b[cap_n] = msg_byte;
      cap_l[cap_n] = msg_last;
      cap_c[cap_n] = cyc;
      cap_n = cap_n + 1;
    end
    if (frame_err) err_n = err_n + 1;
    if (overrun) ovr_n = ovr_n + 1;
    if (msg_valid) vld_n = vld_n + 1;
    if ((frame_err && err_prev) || (overrun && ovr_prev)) dbl_n = dbl_n + 1;
    err_prev = frame_err;
    ovr_prev = overrun;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_n = vec_n + 1;
    assert (obs === exp) else begin
      miss_n = miss_n + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_dv   = 1'b1;
    rx_byte = b;
    step(1);
    rx_dv   = 1'b0;
  endtask

  task automatic send_ck(input logic [7:0] b);
    if (CK) send(b);
  endtask

  task automatic chk_two(input string tag, input int base, input logic [7:0] b0, input logic [7:0] b1);
    chk({tag, "_cnt"}, cap_n - base, 2);
    chk({tag, "_b0"}, 32'(cap_b[base]), 32'(b0));
    chk({tag, "_b1"}, 32'(cap_b[base+1]), 32'(b1));
    chk({tag, "_last"}, {30'd0, cap_l[base], cap_l[base+1]}, 32'h1);
  endtask

  int base;
  int e0;
  int v0;
  int o0;

  initial begin
    rst_n     = 1'b0;
    rx_dv     = 1'b0;
    rx_byte   = 8'h00;
    msg_ready = 1'b1;
    step(2);
    chk("rst_valid", 32'(msg_valid), 32'h0);
    chk("rst_byte",  32'(msg_byte),  32'h0);
    chk("rst_last",  32'(msg_last),  32'h0);
    chk("rst_err",   32'(frame_err), 32'h0);
    chk("rst_ovr",   32'(overrun),   32'h0);
    chk("rst_busy",  32'(busy),      32'h0);
    rst_n = 1'b1;
    step(2);

    // Good three-byte frame, consumer always ready.
    base = cap_n; e0 = err_n;
    send(8'h7E); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send_ck(8'h03);
    chk("a_latency", 32'(msg_valid), 32'h1);
    step(5);
    chk("a_cnt", cap_n - base, 3);
    chk("a_b0", 32'(cap_b[base]),   32'h11);
    chk("a_b1", 32'(cap_b[base+1]), 32'h22);
    chk("a_b2", 32'(cap_b[base+2]), 32'h33);
    chk("a_last", {29'd0, cap_l[base], cap_l[base+1], cap_l[base+2]}, 32'h1);
    chk("a_consec", cap_c[base+2] - cap_c[base], 2);
    chk("a_noerr", err_n - e0, 0);
    chk("a_idle", 32'(busy), 32'h0);

`ifdef UART_RX_FRAMER_CKSUM_EN
    // Same frame with a wrong checksum.
    e0 = err_n; v0 = vld_n;
    send(8'h7E); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h04);
    chk("ck_err", 32'(frame_err), 32'h1);
    chk("ck_busy", 32'(busy), 32'h0);
    step(3);
    chk("ck_pulses", err_n - e0, 1);
    chk("ck_novalid", vld_n - v0, 0);
`endif

    // Length of zero and of MAX_LEN+1 are both rejected.
    e0 = err_n;
    send(8'h7E); send(8'h00);
    chk("len0_err", 32'(frame_err), 32'h1);
    chk("len0_busy", 32'(busy), 32'h0);
    step(1);
    send(8'h7E); send(8'h11);
    chk("len17_err", 32'(frame_err), 32'h1);
    chk("len17_busy", 32'(busy), 32'h0);
    step(2);
    chk("len_pulses", err_n - e0, 2);
    base = cap_n;
    send(8'h7E); send(8'h01); send(8'h5A); send_ck(8'h5B);
    step(3);
    chk("len_next_cnt", cap_n - base, 1);
    chk("len_next_b", 32'(cap_b[base]), 32'h5A);
    chk("len_next_last", 32'(cap_l[base]), 32'h1);

    // Inter-byte silence of TIMEOUT_CLKS clocks aborts the frame.
    e0 = err_n; v0 = vld_n;
    send(8'h7E); send(8'h02); send(8'hAA);
    step(TMO - 1);
    chk("tmo_pre_err", 32'(frame_err), 32'h0);
    chk("tmo_pre_busy", 32'(busy), 32'h1);
    step(1);
    chk("tmo_err", 32'(frame_err), 32'h1);
    chk("tmo_busy", 32'(busy), 32'h0);
    step(2);
    chk("tmo_pulses", err_n - e0, 1);
    chk("tmo_novalid", vld_n - v0, 0);

    // A byte landing on the expiry clock keeps the frame alive.
    e0 = err_n; base = cap_n;
    send(8'h7E); send(8'h02); send(8'hAA);
    step(TMO - 1);
    send(8'hBB); send_ck(8'h13);
    step(4);
    chk("race_noerr", err_n - e0, 0);
    chk_two("race", base, 8'hAA, 8'hBB);

    // Stalled consumer plus a new SOF during DRAIN.
    msg_ready = 1'b0;
    base = cap_n; o0 = ovr_n;
    send(8'h7E); send(8'h02); send(8'hC3); send(8'h3C); send_ck(8'hFD);
    step(3);
    chk("ovr_valid", 32'(msg_valid), 32'h1);
    chk("ovr_hold_b", 32'(msg_byte), 32'hC3);
    send(8'h7E);
    chk("ovr_pulse", 32'(overrun), 32'h1);
    chk("ovr_hold_b2", 32'(msg_byte), 32'hC3);
    step(1);
    chk("ovr_clear", 32'(overrun), 32'h0);
    chk("ovr_pulses", ovr_n - o0, 1);
    msg_ready = 1'b1;
    step(4);
    chk_two("ovr", base, 8'hC3, 8'h3C);
    chk("ovr_idle", 32'(busy), 32'h0);

    // Asynchronous reset during DRAIN.
    e0 = err_n;
    msg_ready = 1'b0;
    send(8'h7E); send(8'h01); send(8'h99); send_ck(8'h98);
    step(1);
    chk("rd_valid", 32'(msg_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rd_valid0", 32'(msg_valid), 32'h0);
    chk("rd_byte0",  32'(msg_byte),  32'h0);
    chk("rd_busy0",  32'(busy),      32'h0);
    step(1);
    rst_n = 1'b1;
    msg_ready = 1'b1;
    step(1);

    // Asynchronous reset during DATA, then a clean frame.
    send(8'h7E); send(8'h03); send(8'h11);
    #2 rst_n = 1'b0;
    #1;
    chk("rdat_busy0", 32'(busy), 32'h0);
    chk("rdat_valid0", 32'(msg_valid), 32'h0);
    step(1);
    rst_n = 1'b1;
    step(1);
    base = cap_n;
    send(8'h7E); send(8'h02); send(8'h55); send(8'h66); send_ck(8'h31);
    step(4);
    chk_two("post_rst", base, 8'h55, 8'h66);
    chk("rst_noerr", err_n - e0, 0);
    chk("single_pulses", dbl_n, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_n, miss_n);
    $finish;
  end

endmodule
